// File: rtl/loader_pkg.sv
// loader_pkg: shared types and widths for the instruction-memory boot loader.
package loader_pkg;
  localparam int WORD_W = 16;
  localparam int CSUM_W = 16;
  typedef enum logic [2:0] {HDR, DATA, CSUM, START, DONE, ERR} state_t;
endpackage

// File: rtl/loader_csum_acc.sv
// loader_csum_acc: wrapping additive checksum accumulator with clear, add-enable and compare.
module loader_csum_acc
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [CSUM_W-1:0] din,
  input  logic [CSUM_W-1:0] cmp,
  output logic              match
);
  logic [CSUM_W-1:0] sum;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (add) sum <= sum + din;
  end
  assign match = sum == cmp;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed image over a valid/ready stream, writes it to instruction
// memory, verifies the checksum and releases the core with a one-cycle start pulse.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              start,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_written
);
  state_t state, state_nx;
  logic [15:0] count, n_len, cnt_nx;
  logic xfer, acc, clr, csum_ok;
  assign xfer   = in_valid && in_ready;
  assign acc    = xfer && state == DATA;
  assign cnt_nx = count + 16'd1;
  assign clr    = (state == DONE || state == ERR) && reload;

  loader_csum_acc u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .add  (acc),
    .din  (in_data),
    .cmp  (in_data),
    .match(csum_ok)
  );

  always_comb begin
    state_nx = state;
    case (state)
      HDR:       if (xfer) state_nx = in_data == '0 ? CSUM : 32'(in_data) > 32'(MAX_WORDS) ? ERR : DATA;
      DATA:      if (acc && cnt_nx == n_len) state_nx = CSUM;
      CSUM:      if (xfer) state_nx = csum_ok ? START : ERR;
      START:     state_nx = DONE;
      DONE, ERR: if (reload) state_nx = HDR;
      default:   state_nx = HDR;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HDR;
      in_ready      <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      words_written <= '0;
      count         <= '0;
      n_len         <= '0;
    end else begin
      state      <= state_nx;
      in_ready   <= state_nx inside {HDR, DATA, CSUM};
      busy       <= state_nx inside {DATA, CSUM};
      start      <= state_nx == START;
      load_done  <= state_nx == DONE;
      load_error <= state_nx == ERR;
      imem_we    <= acc;
      if (acc) begin
        imem_addr     <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
        imem_wdata    <= in_data;
        count         <= cnt_nx;
        words_written <= cnt_nx;
      end else if (clr) begin
        count         <= '0;
        words_written <= '0;
      end
      if (state == HDR && xfer) n_len <= in_data;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven directed bench plus hand sequences for wrap, backpressure and reset abort.
module tb_imem_boot_loader;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, reload = 1'b0;
  logic [15:0] in_data = '0;
  logic rdy0, we0, st0, bz0, dn0, er0, rdy1, we1, st1, bz1, dn1, er1;
  logic [19:0] addr0;
  logic [3:0] addr1;
  logic [15:0] wd0, ww0, wd1, ww1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  imem_boot_loader u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0), .reload(reload),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0), .start(st0), .busy(bz0),
    .load_done(dn0), .load_error(er0), .words_written(ww0)
  );

  imem_boot_loader #(.ADDR_W(4), .BASE_ADDR(14)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1), .reload(reload),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .start(st1), .busy(bz1),
    .load_done(dn1), .load_error(er1), .words_written(ww1)
  );

  typedef struct {
    logic rl, v; logic [15:0] d;
    logic rdy, we; logic [19:0] a; logic [15:0] wd;
    logic st, bz, dn, er; logic [15:0] ww;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(logic rl, logic v, logic [15:0] d, logic rdy, logic we, logic [19:0] a,
                              logic [15:0] wd, logic st, logic bz, logic dn, logic er, logic [15:0] ww);
    vec_t t;
    t.rl = rl; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.a = a; t.wd = wd;
    t.st = st; t.bz = bz; t.dn = dn; t.er = er; t.ww = ww;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic rl);
    in_valid = v; in_data = d; reload = rl;
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " rdy"}, 32'(rdy0), 0); chk({nm, " we"}, 32'(we0), 0); chk({nm, " addr"}, 32'(addr0), 0);
    chk({nm, " wdata"}, 32'(wd0), 0); chk({nm, " start"}, 32'(st0), 0); chk({nm, " busy"}, 32'(bz0), 0);
    chk({nm, " done"}, 32'(dn0), 0); chk({nm, " err"}, 32'(er0), 0); chk({nm, " ww"}, 32'(ww0), 0);
  endtask

  initial begin
    logic wv[7];
    logic [15:0] wdat[7];
    int k, starts;
    //                rl v  d          rdy we a  wd       st bz dn er ww
    tbl[0]  = mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 16'd3,    1, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 16'h1111, 1, 1, 0, 16'h1111, 0, 1, 0, 0, 1);
    tbl[3]  = mk(0, 1, 16'h2222, 1, 1, 1, 16'h2222, 0, 1, 0, 0, 2);
    tbl[4]  = mk(0, 1, 16'h3333, 1, 1, 2, 16'h3333, 0, 1, 0, 0, 3);
    tbl[5]  = mk(0, 1, 16'h6666, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 3);
    tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 3);
    tbl[7]  = mk(0, 1, 16'h1234, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 3);
    tbl[8]  = mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 16'd2,    1, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 16'h0001, 1, 1, 0, 16'h0001, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 1, 16'h0002, 1, 1, 1, 16'h0002, 0, 1, 0, 0, 2);
    tbl[12] = mk(0, 1, 16'h0004, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 2);
    tbl[13] = mk(0, 1, 16'h0003, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 2);
    tbl[14] = mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    tbl[19] = mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 1, 16'd4097, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0);
    tbl[21] = mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);

    #12 chk_idle("reset");
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rl);
      chk($sformatf("v%0d rdy", i), 32'(rdy0), 32'(tbl[i].rdy));
      chk($sformatf("v%0d we", i), 32'(we0), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d addr", i), 32'(addr0), 32'(tbl[i].a));
        chk($sformatf("v%0d wdata", i), 32'(wd0), 32'(tbl[i].wd));
      end
      chk($sformatf("v%0d start", i), 32'(st0), 32'(tbl[i].st));
      chk($sformatf("v%0d busy", i), 32'(bz0), 32'(tbl[i].bz));
      chk($sformatf("v%0d done", i), 32'(dn0), 32'(tbl[i].dn));
      chk($sformatf("v%0d err", i), 32'(er0), 32'(tbl[i].er));
      chk($sformatf("v%0d ww", i), 32'(ww0), 32'(tbl[i].ww));
      chk($sformatf("v%0d excl", i), 32'(dn0 && er0), 0);
    end

    // Wrap with gaps: base 14 on a 4-bit address space, payload sum wraps to 0x0605.
    wv   = '{1, 0, 0, 1, 0, 1, 1};
    wdat = '{16'h0101, 16'hDEAD, 16'hDEAD, 16'h0202, 16'hDEAD, 16'h0303, 16'hFFFF};
    step(1, 16'd4, 0);
    chk("wrap hdr busy", 32'(bz1), 1);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      step(wv[i], wdat[i], 0);
      chk($sformatf("wrap s%0d we", i), 32'(we1), 32'(wv[i]));
      if (wv[i]) begin
        chk($sformatf("wrap s%0d addr", i), 32'(addr1), 32'((14 + k) % 16));
        chk($sformatf("wrap s%0d wdata", i), 32'(wd1), 32'(wdat[i]));
        k++;
        chk($sformatf("wrap s%0d ww", i), 32'(ww1), 32'(k));
      end
      chk($sformatf("wrap s%0d busy", i), 32'(bz1), 1);
    end
    step(1, 16'h0605, 0);
    chk("wrap start", 32'(st1), 1);
    chk("wrap err", 32'(er1), 0);
    step(0, 0, 0);
    chk("wrap done", 32'(dn1), 1);
    step(0, 0, 1);
    chk("wrap reload rdy", 32'(rdy1), 1);

    // Reset asserted between edges after 2 of 5 payload words.
    step(1, 16'd5, 0);
    step(1, 16'h1000, 0);
    step(1, 16'h2000, 0);
    chk("abort pre we", 32'(we0), 1);
    chk("abort pre addr", 32'(addr0), 1);
    #2 rst = 1'b0;
    #1 chk_idle("abort");
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    step(0, 0, 0);
    chk("abort rdy back", 32'(rdy0), 1);
    starts = 0;
    step(1, 16'd1, 0);    starts += int'(st0);
    step(1, 16'hABCD, 0); starts += int'(st0);
    chk("abort2 we", 32'(we0), 1);
    chk("abort2 addr", 32'(addr0), 0);
    step(1, 16'hABCD, 0); starts += int'(st0);
    step(0, 0, 0);        starts += int'(st0);
    step(0, 0, 0);        starts += int'(st0);
    chk("abort2 starts", 32'(starts), 1);
    chk("abort2 done", 32'(dn0), 1);
    chk("abort2 ww", 32'(ww0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder of the processor pipeline. After reset it receives a framed program image over a 16-bit valid/ready stream and writes it word-by-word into instruction memory.
- Verifies a 16-bit additive checksum over the payload.
- On success, issues a one-cycle `start` pulse to the processor. On failure, it never releases the core.

Parameters:
- ADDR_W, 20, instruction-memory word-address width.
- BASE_ADDR, 0, first instruction-memory address written.
- MAX_WORDS, 4096, largest accepted payload length in words.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  stream word valid.
- in_data  input  16  stream word.
- in_ready  output  1  loader can accept a word this cycle.
- reload  input  1  restart framing from DONE or ERR.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  instruction-memory write address.
- imem_wdata  output  16  instruction-memory write data.
- start  output  1  one-cycle pulse that starts the processor.
- busy  output  1  high while a frame is in progress.
- load_done  output  1  level; image loaded and verified.
- load_error  output  1  level; frame rejected.
- words_written  output  16  payload words written in the current frame.

Behaviour:
- Frame format: header word N (payload length), then N payload words, then one checksum word. Checksum = sum of the payload words modulo 2^16.
- Transfer rule: a word transfers only when in_valid && in_ready on a rising edge. When in_valid is low, nothing changes.
- Reset values (rst low, asynchronous): state=HDR, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, start=0, busy=0, load_done=0, load_error=0, words_written=0, count=0, csum=0.
- in_ready rule: in_ready is registered. It rises the cycle after rst deasserts and is high only in HDR, DATA and CSUM.
- HDR state:
  - On transfer, latch N and set busy=1.
  - N=0 -> CSUM.
  - N>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA state:
  - On each transfer, register imem_we=1, imem_addr=(BASE_ADDR+count) mod 2^ADDR_W and imem_wdata=in_data. These appear in the cycle after the accept; write latency is 1 cycle.
  - Also csum+=in_data (16-bit wrap), count+=1, words_written=count+1.
  - imem_we is low in every cycle without a payload accept, and never asserts outside DATA accepts.
  - Leave for CSUM when count reaches N.
- CSUM state: on transfer, in_data==csum -> START; otherwise -> ERR.
- START state: start=1 for exactly one cycle, in_ready=0, busy=0, then -> DONE.
- DONE state: load_done=1, in_ready=0.
- ERR state: load_error=1, busy=0, in_ready=0, start never asserted.
- reload: sampled high in DONE or ERR -> HDR next cycle, clearing load_done, load_error, count, csum and words_written. reload in any other state is ignored.
- Backpressure: gaps in in_valid of any length are allowed mid-frame. State, count and csum hold through gaps.
- Reset mid-frame: asynchronous abort. Words already written stay in memory; the frame restarts from HDR; no start pulse is issued.
- Address wrap: BASE_ADDR+count wraps modulo 2^ADDR_W; no error is raised.
- Exclusivity: load_done and load_error are never high together.

Decomposition:
- Shared package `loader_pkg`:
  - state enum {HDR, DATA, CSUM, START, DONE, ERR};
  - constant WORD_W=16;
  - checksum-width constant.
- One natural sub-module, `loader_csum_acc`: a 16-bit wrapping accumulator with clear and add-enable, plus a compare output against an input word.
- The FSM, counters and memory-write registering stay in the top module.

Test Plan:
- Good frame: stream 3,0x1111,0x2222,0x3333,0x6666 with BASE_ADDR=0 -> writes mem[0..2]=0x1111,0x2222,0x3333, each 1 cycle after accept; start high one cycle; load_done=1; words_written=3.
- Bad checksum: stream 2,0x0001,0x0002,0x0004 -> two writes, then load_error=1, start never pulses, in_ready=0; reload pulse -> HDR with words_written=0.
- Empty and oversize frames: stream 0,0x0000 -> no imem_we, start pulses, load_done=1. Separately, header 4097 with MAX_WORDS=4096 -> ERR immediately, no writes.
- Backpressure and wrap: in_valid toggled 1-0-0-1 across a 4-word frame with ADDR_W=4, BASE_ADDR=14 -> addresses 14,15,0,1; checksum still accepted; no write in gap cycles.
- Reset mid-frame: rst low after 2 of 5 payload words -> all outputs return to reset values asynchronously. A subsequent full valid frame loads normally and pulses start exactly once.
